// File: rtl/xgmac_axis_converter.sv
`default_nettype none
// ============================================================================
//  Module      : xgmac_axis_converter
//  Description : Bridges the XGMAC 64-bit client interface to a pair of
//                64-bit AXI4-Stream ports. RX frames are buffered with their
//                good/bad status on tuser of the last beat. TX frames are
//                stored and forwarded, then replayed to the MAC with the
//                tx_start/tx_ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module xgmac_axis_converter #(
   parameter int RX_FIFO_DEPTH = 512,
   parameter int TX_FIFO_DEPTH = 512
) (
   input  logic        clk156,
   input  logic        reset,
   output logic [63:0] tx_data,
   output logic [7:0]  tx_data_valid,
   output logic        tx_start,
   input  logic        tx_ack,
   input  logic [63:0] rx_data,
   input  logic [7:0]  rx_data_valid,
   input  logic        rx_good_frame,
   input  logic        rx_bad_frame,
   output logic [63:0] m_axis_tdata,
   output logic [7:0]  m_axis_tkeep,
   output logic        m_axis_tuser,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   input  logic [63:0] s_axis_tdata,
   input  logic [7:0]  s_axis_tkeep,
   input  logic        s_axis_tuser,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tlast,
   output logic        s_axis_tready
);
   localparam int RX_AW = $clog2(RX_FIFO_DEPTH);
   localparam int TX_AW = $clog2(TX_FIFO_DEPTH);
   // A non-last RX word may only be stored if one entry stays free for the last word
   localparam logic [RX_AW:0] RX_ROOM_LVL = (RX_AW+1)'(RX_FIFO_DEPTH - 2);
   localparam logic [TX_AW:0] TX_DEPTH_W  = (TX_AW+1)'(TX_FIFO_DEPTH);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_SEND  = 3'd3;
   localparam logic [2:0] ST_FLUSH = 3'd4;

   logic [1:0]       rst_sync;
   logic             rst_n;
   // RX side state
   logic [63:0]      hold_data;
   logic [7:0]       hold_keep;
   logic             hold_valid;
   logic             overflow;
   logic             rx_word, rx_status, rx_room;
   logic             rx_push, rx_drop, rx_push_last, rx_push_user, rx_pop, rx_empty;
   logic [73:0]      rx_mem [RX_FIFO_DEPTH];
   logic [73:0]      rx_head;
   logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [RX_AW:0]   rx_count;
   // TX side state
   logic [72:0]      tx_mem [TX_FIFO_DEPTH];
   logic [72:0]      tx_head;
   logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [TX_AW:0]   tx_count;
   logic [TX_AW:0]   frame_cnt;
   logic             tx_en, tx_wr, tx_pop, tx_full, tx_empty, head_last;
   logic [2:0]       state, state_nxt;
   logic             unused_tuser;

   assign unused_tuser = s_axis_tuser;

   // Assert reset asynchronously, release it on a clock edge
   always_ff @(posedge clk156 or negedge reset) begin
      if (!reset) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   // ------------------------------------------------------------------ RX
   assign rx_word      = |rx_data_valid;
   assign rx_status    = rx_good_frame | rx_bad_frame;
   assign rx_room      = (rx_count <= RX_ROOM_LVL);
   assign rx_push_user = rx_bad_frame | overflow;   // bad wins over good
   assign rx_empty     = (rx_count == '0);
   assign rx_pop       = m_axis_tvalid & m_axis_tready;
   assign rx_head      = rx_mem[rx_rd_ptr];

   // Decide whether the held word is pushed (as last or not) or dropped
   always_comb begin
      rx_push      = 1'b0;
      rx_drop      = 1'b0;
      rx_push_last = 1'b0;
      if (hold_valid && rx_status) begin
         rx_push      = 1'b1;
         rx_push_last = 1'b1;
      end else if (hold_valid && rx_word) begin
         if (rx_room) rx_push = 1'b1;
         else         rx_drop = 1'b1;
      end
   end

   // Hold register delays each word by one so the last one can await its status
   always_ff @(posedge clk156 or negedge rst_n) begin
      if (!rst_n) begin
         hold_data  <= '0;
         hold_keep  <= '0;
         hold_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (rx_word) begin
            hold_data  <= rx_data;
            hold_keep  <= rx_data_valid;
            hold_valid <= 1'b1;
         end else if (hold_valid && rx_status) begin
            hold_valid <= 1'b0;
         end
         if (rx_push && rx_push_last) overflow <= 1'b0;
         else if (rx_drop)            overflow <= 1'b1;
      end
   end

   // RX storage array (no reset needed, validity tracked by the pointers)
   always_ff @(posedge clk156) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= {rx_push_last, rx_push_last & rx_push_user, hold_keep, hold_data};
   end

   // RX FIFO pointers and occupancy
   always_ff @(posedge clk156 or negedge rst_n) begin
      if (!rst_n) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: rx_count <= rx_count;
         endcase
      end
   end

   assign m_axis_tvalid = ~rx_empty;
   assign m_axis_tdata  = rx_empty ? 64'd0 : rx_head[63:0];
   assign m_axis_tkeep  = rx_empty ? 8'd0  : rx_head[71:64];
   assign m_axis_tuser  = ~rx_empty & rx_head[72];
   assign m_axis_tlast  = ~rx_empty & rx_head[73];

   // ------------------------------------------------------------------ TX
   assign tx_full       = (tx_count == TX_DEPTH_W);
   assign tx_empty      = (tx_count == '0);
   assign s_axis_tready = tx_en & ~tx_full;
   assign tx_wr         = s_axis_tvalid & s_axis_tready;
   assign tx_head       = tx_mem[tx_rd_ptr];
   assign head_last     = tx_head[72];

   // TX storage array
   always_ff @(posedge clk156) begin
      if (tx_wr) tx_mem[tx_wr_ptr] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
   end

   // TX FIFO pointers, occupancy, completed-frame count and ready enable
   always_ff @(posedge clk156 or negedge rst_n) begin
      if (!rst_n) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
         frame_cnt <= '0;
         tx_en     <= 1'b0;
      end else begin
         tx_en <= 1'b1;
         if (tx_wr)  tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_pop) tx_rd_ptr <= tx_rd_ptr + 1'b1;
         case ({tx_wr, tx_pop})
            2'b10:   tx_count <= tx_count + 1'b1;
            2'b01:   tx_count <= tx_count - 1'b1;
            default: tx_count <= tx_count;
         endcase
         case ({tx_wr & s_axis_tlast, tx_pop & head_last})
            2'b10:   frame_cnt <= frame_cnt + 1'b1;
            2'b01:   frame_cnt <= frame_cnt - 1'b1;
            default: frame_cnt <= frame_cnt;
         endcase
      end
   end

   // Frame replay sequencing; an underrun ends the frame and discards its tail
   always_comb begin
      state_nxt     = state;
      tx_pop        = 1'b0;
      tx_start      = 1'b0;
      tx_data       = 64'd0;
      tx_data_valid = 8'd0;
      case (state)
         ST_IDLE: begin
            if (frame_cnt != '0 || tx_full) state_nxt = ST_START;
         end
         ST_START: begin
            tx_start      = 1'b1;
            tx_data       = tx_head[63:0];
            tx_data_valid = tx_head[71:64];
            state_nxt     = ST_WAIT;
         end
         ST_WAIT: begin
            tx_data       = tx_head[63:0];
            tx_data_valid = tx_head[71:64];
            if (tx_ack) begin
               tx_pop    = 1'b1;
               state_nxt = head_last ? ST_IDLE : ST_SEND;
            end
         end
         ST_SEND: begin
            if (!tx_empty) begin
               tx_data       = tx_head[63:0];
               tx_data_valid = tx_head[71:64];
               tx_pop        = 1'b1;
               if (head_last) state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (!tx_empty) begin
               tx_pop = 1'b1;
               if (head_last) state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // TX state register
   always_ff @(posedge clk156 or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end
endmodule
`default_nettype wire

// File: tb/tb_xgmac_axis_converter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_xgmac_axis_converter
//  Description : Directed bench for xgmac_axis_converter (RX status tagging,
//                overflow truncation, TX replay handshake, mid-frame reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xgmac_axis_converter;
   logic        clk156 = 1'b0;
   logic        reset  = 1'b1;
   logic [63:0] tx_data;
   logic [7:0]  tx_data_valid;
   logic        tx_start;
   logic        tx_ack = 1'b0;
   logic [63:0] rx_data = '0;
   logic [7:0]  rx_data_valid = '0;
   logic        rx_good_frame = 1'b0;
   logic        rx_bad_frame = 1'b0;
   logic [63:0] m_axis_tdata;
   logic [7:0]  m_axis_tkeep;
   logic        m_axis_tuser, m_axis_tvalid, m_axis_tlast;
   logic        m_axis_tready = 1'b1;
   logic [63:0] s_axis_tdata = '0;
   logic [7:0]  s_axis_tkeep = '0;
   logic        s_axis_tuser = 1'b0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tready;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic        u;
   } beat_t;

   beat_t       rxq[$];
   beat_t       mon_b;
   int          checks = 0;
   int          errors = 0;
   logic        st_log [64];
   logic [7:0]  v_log  [64];
   logic [63:0] d_log  [64];

   always #3.2 clk156 = ~clk156;

   xgmac_axis_converter #(.RX_FIFO_DEPTH(512), .TX_FIFO_DEPTH(512)) dut (
      .clk156(clk156), .reset(reset),
      .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_start(tx_start), .tx_ack(tx_ack),
      .rx_data(rx_data), .rx_data_valid(rx_data_valid),
      .rx_good_frame(rx_good_frame), .rx_bad_frame(rx_bad_frame),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready)
   );

   // Collect every accepted RX beat
   always @(negedge clk156) begin
      if (reset && m_axis_tvalid && m_axis_tready) begin
         mon_b.d = m_axis_tdata;
         mon_b.k = m_axis_tkeep;
         mon_b.l = m_axis_tlast;
         mon_b.u = m_axis_tuser;
         rxq.push_back(mon_b);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one RX frame: n_full words of 0xFF then one word with lkeep, gap idle cycles, status
   task automatic rx_frame(input string tag, input logic [31:0] base, input int n_full,
                           input logic [7:0] lkeep, input int gap, input logic bad);
      int nl;
      for (int i = 0; i <= n_full; i++) begin
         rx_data       = {base, 32'(i)};
         rx_data_valid = (i == n_full) ? lkeep : 8'hFF;
         @(posedge clk156); #1;
      end
      rx_data_valid = 8'h00;
      rx_data       = '0;
      repeat (gap) begin @(posedge clk156); #1; end
      nl = 0;
      foreach (rxq[j]) if (rxq[j].l) nl++;
      check({tag, "_no_last_before_status"}, nl, 0);
      rx_good_frame = ~bad;
      rx_bad_frame  = bad;
      @(posedge clk156); #1;
      rx_good_frame = 1'b0;
      rx_bad_frame  = 1'b0;
   endtask

   // Wait for n beats and compare against the {base, index} pattern
   task automatic rx_verify(input string tag, input int n, input logic [31:0] base,
                            input int last_idx, input logic [7:0] lkeep, input logic luser);
      int derr, kerr, lerr, uerr;
      beat_t lb;
      for (int t = 0; t < 3000 && rxq.size() < n; t++) @(negedge clk156);
      repeat (4) @(negedge clk156);
      check({tag, "_beats"}, rxq.size(), n);
      derr = 0; kerr = 0; lerr = 0; uerr = 0;
      for (int i = 0; i < rxq.size() && i < n - 1; i++) begin
         if (rxq[i].d !== {base, 32'(i)}) derr++;
         if (rxq[i].k !== 8'hFF) kerr++;
         if (rxq[i].l !== 1'b0) lerr++;
         if (rxq[i].u !== 1'b0) uerr++;
      end
      lb = (rxq.size() >= n) ? rxq[n-1] : '0;
      check({tag, "_data_errs"}, derr, 0);
      check({tag, "_keep_errs"}, kerr, 0);
      check({tag, "_early_last"}, lerr, 0);
      check({tag, "_early_user"}, uerr, 0);
      check({tag, "_last_data"}, lb.d, {base, 32'(last_idx)});
      check({tag, "_last_keep"}, lb.k, lkeep);
      check({tag, "_last_tlast"}, lb.l, 1'b1);
      check({tag, "_last_tuser"}, lb.u, luser);
      rxq.delete();
      @(posedge clk156); #1;
   endtask

   // Push an AXI-S frame of n beats into the TX side
   task automatic axis_send(input string tag, input logic [31:0] base, input int n, input logic [7:0] lkeep);
      int ok;
      ok = 1;
      for (int i = 0; i < n; i++) begin
         s_axis_tdata  = {base, 32'(i)};
         s_axis_tkeep  = (i == n - 1) ? lkeep : 8'hFF;
         s_axis_tlast  = (i == n - 1);
         s_axis_tuser  = 1'b1;
         s_axis_tvalid = 1'b1;
         begin : wait_rdy
            int t;
            for (t = 0; t < 200; t++) begin
               @(negedge clk156);
               if (s_axis_tready) break;
            end
            if (t == 200) ok = 0;
         end
         @(posedge clk156); #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      check({tag, "_tready_seen"}, ok, 1);
   endtask

   // Log n cycles of the MAC side, acking ack_delay cycles after tx_start
   task automatic tx_run(input int ack_delay, input int n_cyc, output int s, output int nstart);
      s = -1;
      nstart = 0;
      for (int k = 0; k < n_cyc; k++) begin
         @(negedge clk156);
         st_log[k] = tx_start;
         v_log[k]  = tx_data_valid;
         d_log[k]  = tx_data;
         if (tx_start) begin
            nstart++;
            if (s < 0) s = k;
         end
         tx_ack = (s >= 0 && k == s + ack_delay);
      end
      tx_ack = 1'b0;
      if (s < 0) s = 0;
      @(posedge clk156); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, ns, err;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk156);
      #1;
      check("rst_tx_data", tx_data, 64'd0);
      check("rst_tx_data_valid", tx_data_valid, 8'd0);
      check("rst_tx_start", tx_start, 1'b0);
      check("rst_m_tvalid", m_axis_tvalid, 1'b0);
      check("rst_m_tlast", m_axis_tlast, 1'b0);
      check("rst_m_tuser", m_axis_tuser, 1'b0);
      check("rst_s_tready", s_axis_tready, 1'b0);
      reset = 1'b1;
      repeat (6) @(posedge clk156);
      #1;

      // RX good frame, status 7 cycles after the last word
      m_axis_tready = 1'b1;
      rx_frame("rxgood", 32'hA0000000, 16, 8'h03, 6, 1'b0);
      rx_verify("rxgood", 17, 32'hA0000000, 16, 8'h03, 1'b0);

      // RX bad frame of 500 words
      rx_frame("rxbad", 32'hB0000000, 499, 8'h03, 3, 1'b1);
      rx_verify("rxbad", 500, 32'hB0000000, 499, 8'h03, 1'b1);

      // RX backpressure for the whole frame
      m_axis_tready = 1'b0;
      rx_frame("rxbp", 32'hC0000000, 8, 8'h0F, 2, 1'b0);
      m_axis_tready = 1'b1;
      rx_verify("rxbp", 9, 32'hC0000000, 8, 8'h0F, 1'b0);

      // RX overflow: 601 words into 512 entries, 511 body words kept plus the last word
      m_axis_tready = 1'b0;
      rx_frame("rxovf", 32'hD0000000, 600, 8'h03, 2, 1'b0);
      m_axis_tready = 1'b1;
      rx_verify("rxovf", 512, 32'hD0000000, 600, 8'h03, 1'b1);

      // TX 17-beat frame, ack 5 cycles after start
      axis_send("tx17", 32'hE0000000, 17, 8'h03);
      tx_run(5, 32, s, ns);
      check("tx17_start_pulses", ns, 1);
      check("tx17_start_cycle", s, 1);
      check("tx17_idle_before", v_log[0], 8'h00);
      err = 0;
      for (int k = s; k <= s + 5; k++)
         if (v_log[k] !== 8'hFF || d_log[k] !== {32'hE0000000, 32'd0}) err++;
      check("tx17_hold_errs", err, 0);
      err = 0;
      for (int j = 1; j <= 15; j++)
         if (v_log[s+5+j] !== 8'hFF || d_log[s+5+j] !== {32'hE0000000, 32'(j)}) err++;
      check("tx17_stream_errs", err, 0);
      check("tx17_last_valid", v_log[s+21], 8'h03);
      check("tx17_last_data", d_log[s+21], {32'hE0000000, 32'd16});
      check("tx17_end_valid", v_log[s+22], 8'h00);
      check("tx17_frame_cnt", dut.frame_cnt, 0);

      // TX single-word frame
      axis_send("tx1", 32'hF0000000, 1, 8'h0F);
      tx_run(2, 16, s, ns);
      check("tx1_start_pulses", ns, 1);
      err = 0;
      for (int k = s; k <= s + 2; k++)
         if (v_log[k] !== 8'h0F || d_log[k] !== {32'hF0000000, 32'd0}) err++;
      check("tx1_hold_errs", err, 0);
      check("tx1_end_valid", v_log[s+3], 8'h00);
      check("tx1_frame_cnt", dut.frame_cnt, 0);

      // Reset in the middle of an RX frame and a TX handshake
      m_axis_tready = 1'b0;
      rx_data       = 64'h1234_5678_9ABC_DEF0;
      rx_data_valid = 8'hFF;
      axis_send("txrst", 32'h99990000, 3, 8'hFF);
      for (int t = 0; t < 20; t++) begin
         @(negedge clk156);
         if (tx_start) break;
      end
      @(negedge clk156);
      check("pre_rst_tx_valid", tx_data_valid, 8'hFF);
      check("pre_rst_m_tvalid", m_axis_tvalid, 1'b1);
      #1 reset = 1'b0;
      #1;
      check("mid_rst_tx_data", tx_data, 64'd0);
      check("mid_rst_tx_valid", tx_data_valid, 8'd0);
      check("mid_rst_tx_start", tx_start, 1'b0);
      check("mid_rst_m_tvalid", m_axis_tvalid, 1'b0);
      check("mid_rst_m_tlast", m_axis_tlast, 1'b0);
      check("mid_rst_m_tuser", m_axis_tuser, 1'b0);
      check("mid_rst_s_tready", s_axis_tready, 1'b0);
      rx_data_valid = 8'h00;
      rx_data       = '0;
      m_axis_tready = 1'b1;
      repeat (3) @(posedge clk156);
      #1 reset = 1'b1;
      repeat (6) @(posedge clk156);
      #1;
      rxq.delete();

      // Clean traffic after the reset
      rx_frame("rxpost", 32'h77770000, 3, 8'hF0, 2, 1'b0);
      rx_verify("rxpost", 4, 32'h77770000, 3, 8'hF0, 1'b0);
      axis_send("txpost", 32'h88880000, 2, 8'h3F);
      tx_run(1, 16, s, ns);
      check("txpost_start_pulses", ns, 1);
      check("txpost_first_data", d_log[s], {32'h88880000, 32'd0});
      check("txpost_first_valid", v_log[s], 8'hFF);
      check("txpost_second_data", d_log[s+2], {32'h88880000, 32'd1});
      check("txpost_second_valid", v_log[s+2], 8'h3F);
      check("txpost_end_valid", v_log[s+3], 8'h00);
      check("txpost_frame_cnt", dut.frame_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/xgmac_axis_converter.md
Name: xgmac_axis_converter

Overview:
Bridges the Xilinx XGMAC client interface (64-bit, 156.25 MHz) to a pair of 64-bit AXI4-Stream ports.
- RX: XGMAC frames are buffered and emitted on m_axis. Frame status (good/bad) arrives after the last data word and is carried on tuser of the last beat.
- TX: s_axis frames are buffered store-and-forward, then replayed to the MAC using the tx_start/tx_ack protocol with no gaps.
- Sits between the 10G MAC core and the switch datapath.

Parameters:
RX_FIFO_DEPTH  512  RX buffer depth in 64-bit words (power of 2)
TX_FIFO_DEPTH  512  TX buffer depth in 64-bit words (power of 2)

Ports:
clk156  in  1  single clock for all logic
reset  in  1  asynchronous, active-low reset
tx_data  out  64  data to MAC
tx_data_valid  out  8  byte enables to MAC; bit i = byte i
tx_start  out  1  one-cycle frame-start request
tx_ack  in  1  MAC accepted first word
rx_data  in  64  data from MAC
rx_data_valid  in  8  byte enables from MAC; 0 = no data
rx_good_frame  in  1  status pulse, frame good
rx_bad_frame  in  1  status pulse, frame bad
m_axis_tdata/tkeep/tuser/tvalid/tlast  out  64/8/1/1/1  RX stream; tuser[0]=1 marks a bad frame
m_axis_tready  in  1
s_axis_tdata/tkeep/tuser/tvalid/tlast  in  64/8/1/1/1  TX stream; tuser is ignored
s_axis_tready  out  1

Behaviour:
Reset (asynchronous assert, synchronous release):
- Both FIFOs are emptied and both state machines return to idle.
- tx_data=0, tx_data_valid=0, tx_start=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, s_axis_tready=0.

RX path:
- Each cycle with rx_data_valid!=0, the word is captured into a one-word hold register; the previously held word is pushed to the RX FIFO with last=0.
- When rx_data_valid returns to 0, the held word is the last word. It stays held until rx_good_frame or rx_bad_frame pulses (any later cycle).
- On the status pulse, the held word is pushed with last=1 and tuser = rx_bad_frame OR overflow flag. The pulse may arrive up to 8 cycles after the last data word.
- Non-last pushes require at least 2 free entries. Otherwise the word is dropped and a sticky overflow flag is set, cleared after the last-word push. This guarantees the last word always fits.
- Good and bad asserted together is treated as bad.
- A status pulse with no held word is ignored.
- m_axis_tdata = stored rx_data; m_axis_tkeep = stored rx_data_valid.
- m_axis_tvalid = FIFO not empty. A beat pops when tvalid & tready.
- Payload is never altered.

TX path:
- s_axis_tready = TX FIFO not full (and not in reset). A beat is written when tvalid & tready.
- Storage per beat: tdata, tkeep, tlast.
- A completed-frame counter increments on each tlast write and decrements when a frame's last word is sent to the MAC.

TX state machine:
- IDLE: tx_data_valid=0. Go to START when the completed-frame count is >0 or the FIFO is full (oversize frame, cut-through).
- START (1 cycle): tx_start=1, tx_data = head word, tx_data_valid = its tkeep. Go to WAIT_ACK.
- WAIT_ACK: tx_start=0; head word and its valid stay on the bus. On tx_ack=1, the head pops in that cycle. If it was tlast, go to IDLE; else go to SEND.
- SEND: each cycle present the next word and pop it. After the tlast word, go to IDLE with tx_data_valid=0 the following cycle.
- The MAC must never see a gap mid-frame. In the cut-through case an empty FIFO in SEND is an underrun; the converter sends tx_data_valid=0, which the MAC treats as frame end.
- At least one idle cycle between frames.
- tkeep of non-last beats is assumed 0xFF; tkeep is passed through unmodified.

Test Plan:
- RX good: 16 words with valid=0xFF, then 1 word with valid=0x03, valid=0; rx_good_frame 7 cycles later; tready=1 -> 17 beats, data order preserved, last beat tkeep=0x03, tlast=1, tuser=0; no beat emitted before the status pulse.
- RX bad: ~500 words 0xFF + 0x03, then rx_bad_frame -> all words out, last beat tuser=1, earlier beats tuser=0.
- TX: 16 beats tkeep=0xFF, then tkeep=0x03 tlast=1; tx_ack ~5 cycles after tx_start -> tx_start is a single-cycle pulse; first word held during the wait; after ack the remaining 16 words appear on consecutive cycles; final tx_data_valid=0x03, then 0x00.
- RX backpressure: m_axis_tready=0 for a whole frame, then 1 -> frame delivered intact. Overflow (frame > FIFO) -> truncated frame with last beat tuser=1.
- Single-word TX frame (tlast on first beat) -> tx_start, ack, then tx_data_valid=0 the next cycle; frame counter returns to 0.
- Reset asserted mid-RX and mid-TX -> all outputs at reset values immediately; after release the next frames pass cleanly.
